// File: rtl/mem_access_ctrl.sv
// Purpose : CPU data-memory access controller (EXE -> SRAM-like bus). Handles
//           alignment exceptions, lane steering, load extension, bus timeout and flush.
// Latency : accept N -> data_req N+1 -> resp_valid N+3 at best. req_ready only in IDLE
//           without flush, so the pipeline stalls on busy. Bus address and data are held until addr_ok.
// Ports   : req_* (EXE request), data_* (memory bus), resp_* (one-cycle result),
//           flush (kill in-flight op), busy (stall source), cpu_clk_50M / cpu_rst (sync, active-high).
module mem_access_ctrl #(
    parameter int                ADDR_W      = 32,
    parameter bit                BYTE_SWAP   = 1'b1,
    parameter logic [ADDR_W-1:0] DEV_BASE    = ADDR_W'(32'hBFAF_F000),
    parameter logic [ADDR_W-1:0] DEV_MASK    = ADDR_W'(32'hFFFF_F000),
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              flush,
    output logic              data_req,
    output logic              data_wr,
    output logic [3:0]        data_wstrb,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_exc,
    output logic [ADDR_W-1:0] resp_badvaddr,
    output logic              busy
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd9;
    localparam logic [3:0] OP_SH  = 4'd10;
    localparam logic [3:0] OP_SW  = 4'd11;

    localparam int               CNT_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DRAIN} state_t;

    function automatic logic [31:0] swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    state_t            state;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic              dev_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q;
    logic [31:0]       res_q;
    logic [1:0]        exc_q;
    logic [CNT_W-1:0]  to_cnt;

    // ---- request decode (IDLE side) ----
    logic        op_vld, op_st, misal, dev_hit, accept, to_hit;
    logic [1:0]  op_sz;   // 0 byte, 1 halfword, 2 word
    logic [3:0]  wstrb_n;
    logic [31:0] wdata_n;

    always_comb begin
        op_vld = 1'b0;
        op_st  = 1'b0;
        op_sz  = 2'd0;
        case (req_op)
            OP_LB, OP_LBU: op_vld = 1'b1;
            OP_LH, OP_LHU: begin op_vld = 1'b1; op_sz = 2'd1; end
            OP_LW:         begin op_vld = 1'b1; op_sz = 2'd2; end
            OP_SB:         begin op_vld = 1'b1; op_st = 1'b1; end
            OP_SH:         begin op_vld = 1'b1; op_st = 1'b1; op_sz = 2'd1; end
            OP_SW:         begin op_vld = 1'b1; op_st = 1'b1; op_sz = 2'd2; end
            default:       ;
        endcase
    end

    assign dev_hit = (req_addr & DEV_MASK) == DEV_BASE;
    assign misal   = ((op_sz == 2'd1) && req_addr[0]) ||
                     ((op_sz == 2'd2) && (req_addr[1:0] != 2'b00));
    assign accept  = req_valid && req_ready && op_vld;

    // Lane 3 holds address offset 0; sub-word store data is replicated to every lane.
    always_comb begin
        wstrb_n = 4'b0000;
        wdata_n = 32'h0;
        if (op_st) begin
            case (op_sz)
                2'd0: begin
                    wstrb_n = 4'b1000 >> req_addr[1:0];
                    wdata_n = {4{req_wdata[7:0]}};
                end
                2'd1: begin
                    wstrb_n = req_addr[1] ? 4'b0011 : 4'b1100;
                    wdata_n = {2{req_wdata[7:0], req_wdata[15:8]}};
                end
                default: begin
                    wstrb_n = 4'b1111;
                    wdata_n = (BYTE_SWAP && !dev_hit) ? swap32(req_wdata) : req_wdata;
                end
            endcase
        end
    end

    // ---- load extraction: same lane map, bytes put back into register order ----
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_res;

    always_comb begin
        ld_b   = data_rdata[{~addr_q[1:0], 3'b000} +: 8];
        ld_h   = addr_q[1] ? {data_rdata[7:0], data_rdata[15:8]}
                           : {data_rdata[23:16], data_rdata[31:24]};
        ld_res = 32'h0;
        case (op_q)
            OP_LB:   ld_res = {{24{ld_b[7]}}, ld_b};
            OP_LBU:  ld_res = {24'h0, ld_b};
            OP_LH:   ld_res = {{16{ld_h[15]}}, ld_h};
            OP_LHU:  ld_res = {16'h0, ld_h};
            OP_LW:   ld_res = (BYTE_SWAP && !dev_q) ? swap32(data_rdata) : data_rdata;
            default: ld_res = 32'h0;   // stores return zero
        endcase
    end

    // Counter runs through DATA and DRAIN and is cleared everywhere else, so it is zero on entry to DATA.
    assign to_hit = (TIMEOUT_CYC != 0) && (to_cnt == CNT_LAST);

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state   <= S_IDLE;
            op_q    <= 4'h0;
            addr_q  <= '0;
            dev_q   <= 1'b0;
            wstrb_q <= 4'h0;
            wdata_q <= 32'h0;
            res_q   <= 32'h0;
            exc_q   <= 2'd0;
            to_cnt  <= '0;
        end else begin
            if ((state == S_DATA) || (state == S_DRAIN)) begin
                to_cnt <= to_cnt + CNT_W'(1);
            end else begin
                to_cnt <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= req_op;
                        addr_q  <= req_addr;
                        dev_q   <= dev_hit;
                        wstrb_q <= wstrb_n;
                        wdata_q <= wdata_n;
                        res_q   <= 32'h0;
                        if (misal) begin
                            exc_q <= op_st ? 2'd2 : 2'd1;
                            state <= S_RESP;
                        end else begin
                            exc_q <= 2'd0;
                            state <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    // An accepted address owes us a data beat, so flush must drain it.
                    if (flush) begin
                        state <= data_addr_ok ? S_DRAIN : S_IDLE;
                    end else if (data_addr_ok) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (flush) begin
                        state <= (data_data_ok || to_hit) ? S_IDLE : S_DRAIN;
                    end else if (data_data_ok) begin
                        res_q <= ld_res;
                        state <= S_RESP;
                    end else if (to_hit) begin
                        res_q <= 32'h0;
                        exc_q <= 2'd3;
                        state <= S_RESP;
                    end
                end
                S_RESP: state <= S_IDLE;
                S_DRAIN: begin
                    if (data_data_ok || to_hit) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    wire in_addr = (state == S_ADDR);
    wire in_resp = (state == S_RESP);

    assign req_ready     = (state == S_IDLE) && !flush && !cpu_rst;
    assign busy          = (state != S_IDLE);
    assign data_req      = in_addr;
    assign data_wr       = in_addr && op_q[3];
    assign data_wstrb    = in_addr ? wstrb_q : 4'h0;
    assign data_addr     = in_addr ? addr_q : '0;
    assign data_wdata    = in_addr ? wdata_q : 32'h0;
    assign resp_valid    = in_resp && !flush;
    assign resp_rdata    = in_resp ? res_q : 32'h0;
    assign resp_exc      = in_resp ? exc_q : 2'd0;
    assign resp_badvaddr = (in_resp && (exc_q != 2'd0)) ? addr_q : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Purpose : directed self-checking bench for mem_access_ctrl (default instance plus a TIMEOUT_CYC=4 instance).
// Latency : inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure : every wait on the DUT is bounded by a cycle budget.
module tb_mem_access_ctrl;
    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst     = 1'b1;
    logic        req_valid   = 1'b0;
    logic [3:0]  req_op      = 4'h0;
    logic [31:0] req_addr    = 32'h0;
    logic [31:0] req_wdata   = 32'h0;
    logic        flush       = 1'b0;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata  = 32'h0;

    logic        req_ready, data_req, data_wr, resp_valid, busy;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, resp_rdata, resp_badvaddr;
    logic [1:0]  resp_exc;

    logic        tmo_req_ready, tmo_data_req, tmo_data_wr, tmo_resp_valid, tmo_busy;
    logic [3:0]  tmo_data_wstrb;
    logic [31:0] tmo_data_addr, tmo_data_wdata, tmo_resp_rdata, tmo_resp_badvaddr;
    logic [1:0]  tmo_resp_exc;

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    mem_access_ctrl u_dut (
        .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
        .resp_badvaddr(resp_badvaddr), .busy(busy)
    );

    mem_access_ctrl #(.TIMEOUT_CYC(4)) u_dut_tmo (
        .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst),
        .req_valid(req_valid), .req_ready(tmo_req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
        .data_req(tmo_data_req), .data_wr(tmo_data_wr), .data_wstrb(tmo_data_wstrb),
        .data_addr(tmo_data_addr), .data_wdata(tmo_data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .resp_valid(tmo_resp_valid), .resp_rdata(tmo_resp_rdata), .resp_exc(tmo_resp_exc),
        .resp_badvaddr(tmo_resp_badvaddr), .busy(tmo_busy)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic mid();
        @(negedge cpu_clk_50M);
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; req_op = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
        flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    endtask

    task automatic do_reset();
        cpu_rst = 1'b1;
        idle_inputs();
        next_cyc();
        next_cyc();
        cpu_rst = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    endtask

    // Results of the last run_op
    logic        r_ready, r_seen, r_wr;
    logic [3:0]  r_strb;
    logic [31:0] r_wdata, r_rdata, r_bad;
    logic [1:0]  r_exc;
    int          r_lat;

    // One op with immediate addr_ok/data_ok; called 1ns after a posedge with the DUT idle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd);
        r_seen = 1'b0; r_wr = 1'b0; r_strb = 4'h0; r_wdata = 32'h0;
        r_rdata = 32'h0; r_bad = 32'h0; r_exc = 2'd0; r_lat = 0;
        issue(op, addr, wd);
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = rd;
        mid();
        r_ready = req_ready;
        next_cyc();
        req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            mid();
            if (data_req) begin
                r_seen = 1'b1; r_strb = data_wstrb; r_wdata = data_wdata; r_wr = data_wr;
            end
            if (resp_valid) begin
                r_lat = k; r_rdata = resp_rdata; r_exc = resp_exc; r_bad = resp_badvaddr;
            end
            next_cyc();
            if (r_lat != 0) break;
        end
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
    endtask

    task automatic chk_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] rd, input logic [31:0] exp);
        run_op(op, addr, 32'h0, rd);
        chk({tag, "_ready"}, r_ready, 1);
        chk({tag, "_lat"}, r_lat, 3);
        chk({tag, "_rdata"}, r_rdata, exp);
        chk({tag, "_strb"}, r_strb, 4'h0);
        chk({tag, "_wr"}, r_wr, 0);
    endtask

    task automatic chk_store(input string tag, input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] strb, input logic [31:0] exp_wd);
        run_op(op, addr, wd, 32'hFFFF_FFFF);
        chk({tag, "_lat"}, r_lat, 3);
        chk({tag, "_strb"}, r_strb, strb);
        chk({tag, "_wdata"}, r_wdata, exp_wd);
        chk({tag, "_wr"}, r_wr, 1);
        chk({tag, "_rdata"}, r_rdata, 32'h0);
    endtask

    task automatic chk_misal(input string tag, input logic [3:0] op, input logic [31:0] addr,
                             input logic [1:0] exc);
        run_op(op, addr, 32'h1234_5678, 32'hFFFF_FFFF);
        chk({tag, "_lat"}, r_lat, 1);
        chk({tag, "_noreq"}, r_seen, 0);
        chk({tag, "_exc"}, r_exc, exc);
        chk({tag, "_bad"}, r_bad, addr);
        chk({tag, "_rdata"}, r_rdata, 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_resp, busy_ok;
        int   lat;

        // ---- reset state ----
        idle_inputs();
        issue(4'd5, 32'h0000_0010, 32'h0);
        next_cyc();
        next_cyc();
        mid();
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req", data_req, 0);
        chk("rst_resp", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_tmo_busy", tmo_busy, 0);
        do_reset();

        // ---- loads: LB at 0x1003 with sign extension, lane and swap selection ----
        chk_load("lb_1003", 4'd1, 32'h0000_1003, 32'h0000_00F0, 32'hFFFF_FFF0);
        chk_load("lw_dev", 4'd5, 32'hBFAF_F008, 32'h1122_3344, 32'h1122_3344);
        chk_load("lw_mem", 4'd5, 32'h0000_0008, 32'h1122_3344, 32'h4433_2211);
        chk_load("lbu_101", 4'd2, 32'h0000_0101, 32'h11A2_3344, 32'h0000_00A2);
        chk_load("lb_101", 4'd1, 32'h0000_0101, 32'h11A2_3344, 32'hFFFF_FFA2);
        chk_load("lh_200", 4'd3, 32'h0000_0200, 32'h80FF_1234, 32'hFFFF_FF80);
        chk_load("lhu_202", 4'd4, 32'h0000_0202, 32'h1234_5680, 32'h0000_8056);
        chk_load("lh_202", 4'd3, 32'h0000_0202, 32'h1234_5680, 32'hFFFF_8056);

        // ---- stores ----
        chk_store("sb_100", 4'd9, 32'h0000_0100, 32'h1234_56AB, 4'b1000, 32'hABAB_ABAB);
        chk_store("sb_102", 4'd9, 32'h0000_0102, 32'h1234_5677, 4'b0010, 32'h7777_7777);
        chk_store("sh_2000", 4'd10, 32'h0000_2000, 32'h0000_ABCD, 4'b1100, 32'hCDAB_CDAB);
        chk_store("sw_mem", 4'd11, 32'h0000_0104, 32'h1122_3344, 4'b1111, 32'h4433_2211);
        chk_store("sw_dev", 4'd11, 32'hBFAF_F004, 32'h1122_3344, 4'b1111, 32'h1122_3344);

        // ---- misaligned ----
        chk_misal("lw_3001", 4'd5, 32'h0000_3001, 2'd1);
        chk_misal("sw_3002", 4'd11, 32'h0000_3002, 2'd2);
        chk_misal("lhu_4003", 4'd4, 32'h0000_4003, 2'd1);
        chk_misal("sh_5001", 4'd10, 32'h0000_5001, 2'd2);

        // ---- SH at 0x2002 held through three cycles of addr_ok=0 ----
        do_reset();
        issue(4'd10, 32'h0000_2002, 32'h0000_ABCD);
        data_data_ok = 1'b1;
        mid();
        chk("sh_hold_ready", req_ready, 1);
        next_cyc();
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("sh_hold_req", data_req, 1);
            chk("sh_hold_strb", data_wstrb, 4'b0011);
            chk("sh_hold_wdata", data_wdata, 32'hCDAB_CDAB);
            chk("sh_hold_wr", data_wr, 1);
            chk("sh_hold_addr", data_addr, 32'h0000_2002);
            next_cyc();
        end
        data_addr_ok = 1'b1;
        mid();
        chk("sh_hold_req_ok", data_req, 1);
        next_cyc();
        data_addr_ok = 1'b0;
        mid();
        chk("sh_hold_data_noreq", data_req, 0);
        chk("sh_hold_data_noresp", resp_valid, 0);
        next_cyc();
        mid();
        chk("sh_hold_resp", resp_valid, 1);
        data_data_ok = 1'b0;
        next_cyc();

        // ---- flush one cycle after addr_ok, data_ok four cycles later ----
        do_reset();
        issue(4'd5, 32'h0000_0040, 32'h0);
        data_addr_ok = 1'b1;
        data_rdata = 32'hDEAD_BEEF;
        mid();
        chk("fl_drain_acc", req_ready, 1);
        next_cyc();
        req_valid = 1'b0;
        mid();
        chk("fl_drain_addr", data_req, 1);
        next_cyc();
        data_addr_ok = 1'b0;
        flush = 1'b1;
        mid();
        chk("fl_drain_ready_flush", req_ready, 0);
        seen_resp = resp_valid;
        next_cyc();
        flush = 1'b0;
        busy_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mid();
            if (resp_valid) seen_resp = 1'b1;
            if (!busy) busy_ok = 1'b0;
            next_cyc();
        end
        data_data_ok = 1'b1;
        mid();
        if (resp_valid) seen_resp = 1'b1;
        chk("fl_drain_busy_dok", busy, 1);
        next_cyc();
        data_data_ok = 1'b0;
        chk("fl_drain_busy_wait", busy_ok, 1);
        chk("fl_drain_no_resp", seen_resp, 0);
        chk("fl_drain_idle", busy, 0);
        run_op(4'd5, 32'h0000_0008, 32'h0, 32'h1122_3344);
        chk("fl_drain_next_acc", r_ready, 1);
        chk("fl_drain_next_lat", r_lat, 3);
        chk("fl_drain_next_rdata", r_rdata, 32'h4433_2211);

        // ---- flush in ADDR without addr_ok ----
        do_reset();
        issue(4'd5, 32'h0000_0040, 32'h0);
        mid();
        next_cyc();
        req_valid = 1'b0;
        flush = 1'b1;
        mid();
        chk("fl_addr_req_now", data_req, 1);
        next_cyc();
        flush = 1'b0;
        mid();
        chk("fl_addr_req_drop", data_req, 0);
        chk("fl_addr_busy", busy, 0);
        chk("fl_addr_resp", resp_valid, 0);

        // ---- flush in ADDR with addr_ok goes through DRAIN ----
        do_reset();
        issue(4'd5, 32'h0000_0040, 32'h0);
        mid();
        next_cyc();
        req_valid = 1'b0;
        flush = 1'b1;
        data_addr_ok = 1'b1;
        mid();
        next_cyc();
        flush = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        mid();
        chk("fl_addrok_busy", busy, 1);
        chk("fl_addrok_noreq", data_req, 0);
        chk("fl_addrok_noresp", resp_valid, 0);
        next_cyc();
        data_data_ok = 1'b0;
        mid();
        chk("fl_addrok_idle", busy, 0);
        chk("fl_addrok_noresp2", resp_valid, 0);

        // ---- flush in DATA together with data_ok ----
        do_reset();
        issue(4'd5, 32'h0000_0040, 32'h0);
        data_addr_ok = 1'b1;
        mid();
        next_cyc();
        req_valid = 1'b0;
        next_cyc();
        data_addr_ok = 1'b0;
        flush = 1'b1;
        data_data_ok = 1'b1;
        mid();
        next_cyc();
        flush = 1'b0;
        data_data_ok = 1'b0;
        mid();
        chk("fl_data_dok_busy", busy, 0);
        chk("fl_data_dok_resp", resp_valid, 0);

        // ---- flush in RESP ----
        do_reset();
        issue(4'd5, 32'h0000_0040, 32'h0);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        mid();
        next_cyc();
        req_valid = 1'b0;
        next_cyc();
        next_cyc();
        flush = 1'b1;
        mid();
        chk("fl_resp_suppr", resp_valid, 0);
        chk("fl_resp_busy", busy, 1);
        next_cyc();
        flush = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        mid();
        chk("fl_resp_idle", busy, 0);
        chk("fl_resp_noresp", resp_valid, 0);

        // ---- flush in IDLE blocks acceptance ----
        do_reset();
        issue(4'd5, 32'h0000_0040, 32'h0);
        flush = 1'b1;
        mid();
        chk("fl_idle_ready", req_ready, 0);
        next_cyc();
        req_valid = 1'b0;
        flush = 1'b0;
        chk("fl_idle_busy", busy, 0);

        // ---- timeout on the TIMEOUT_CYC=4 instance, late data_ok ignored ----
        do_reset();
        issue(4'd5, 32'h0000_0008, 32'h0);
        data_addr_ok = 1'b1;
        mid();
        next_cyc();
        req_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            mid();
            if (tmo_resp_valid) begin
                lat = k;
                chk("tmo_exc", tmo_resp_exc, 2'd3);
                chk("tmo_bad", tmo_resp_badvaddr, 32'h0000_0008);
                chk("tmo_rdata", tmo_resp_rdata, 32'h0);
                chk("tmo_long_busy", busy, 1);
            end
            next_cyc();
            if (lat != 0) break;
        end
        chk("tmo_lat", lat, 6);
        data_data_ok = 1'b1;
        mid();
        chk("tmo_late_dok_resp", tmo_resp_valid, 0);
        next_cyc();
        data_data_ok = 1'b0;
        data_addr_ok = 1'b0;
        mid();
        chk("tmo_late_busy", tmo_busy, 0);
        chk("tmo_late_resp", tmo_resp_valid, 0);

        // ---- reset mid-DATA ----
        do_reset();
        issue(4'd5, 32'h0000_0008, 32'h0);
        data_addr_ok = 1'b1;
        mid();
        next_cyc();
        req_valid = 1'b0;
        next_cyc();
        data_addr_ok = 1'b0;
        mid();
        chk("rst_data_busy_before", busy, 1);
        next_cyc();
        cpu_rst = 1'b1;
        mid();
        next_cyc();
        cpu_rst = 1'b0;
        mid();
        chk("rst_data_busy", busy, 0);
        chk("rst_data_req", data_req, 0);
        chk("rst_data_resp", resp_valid, 0);
        next_cyc();

        // ---- reset mid-ADDR, then accept in the first cycle out of reset ----
        issue(4'd5, 32'h0000_0008, 32'h0);
        mid();
        next_cyc();
        req_valid = 1'b0;
        mid();
        chk("rst_addr_req_before", data_req, 1);
        next_cyc();
        cpu_rst = 1'b1;
        mid();
        next_cyc();
        cpu_rst = 1'b0;
        chk("rst_addr_req", data_req, 0);
        chk("rst_addr_busy", busy, 0);
        run_op(4'd5, 32'hBFAF_F008, 32'h0, 32'hA1B2_C3D4);
        chk("rst_first_acc", r_ready, 1);
        chk("rst_first_lat", r_lat, 3);
        chk("rst_first_rdata", r_rdata, 32'hA1B2_C3D4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the width of the address bus.
REQ-002 The block SHALL have parameter BYTE_SWAP, default 1, meaning lanes are byte-reversed for non-device accesses.
REQ-003 The block SHALL have parameter DEV_BASE, default 32'hBFAF_F000, meaning the device window base address.
REQ-004 The block SHALL have parameter DEV_MASK, default 32'hFFFF_F000, meaning an address is a device access when (addr & DEV_MASK) == DEV_BASE.
REQ-005 The block SHALL have parameter TIMEOUT_CYC, default 255, meaning the maximum number of DATA-state cycles before a bus error (0 disables the timeout).
REQ-006 The block SHALL have the following ports, each given as name, direction, width, meaning:
- cpu_clk_50M, in, 1: the single clock.
- cpu_rst, in, 1: reset, synchronous and active-high.
- req_valid, in, 1: the EXE stage offers an operation.
- req_ready, out, 1: the block accepts in this cycle.
- req_op, in, 4: 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 9=SB, 10=SH, 11=SW; other values are no-ops.
- req_addr, in, ADDR_W: the effective address.
- req_wdata, in, 32: the store data, register-aligned.
- flush, in, 1: an exception or eret kills the in-flight operation.
- data_req, out, 1: the bus request.
- data_wr, out, 1: 1 means write.
- data_wstrb, out, 4: the byte strobes.
- data_addr, out, ADDR_W: the bus address.
- data_wdata, out, 32: the bus write data.
- data_addr_ok, in, 1: the address is accepted.
- data_data_ok, in, 1: the data phase is done.
- data_rdata, in, 32: the read data.
- resp_valid, out, 1: a one-cycle result pulse.
- resp_rdata, out, 32: the extended load result.
- resp_exc, out, 2: 0=none, 1=AdEL, 2=AdES, 3=bus timeout.
- resp_badvaddr, out, ADDR_W: the faulting address.
- busy, out, 1: the block is not IDLE (the pipeline stall source).

Function
REQ-007 The state machine SHALL have the states IDLE, ADDR, DATA, RESP and DRAIN.
REQ-008 req_ready SHALL be 1 only in IDLE with flush=0; an op is accepted when req_valid & req_ready and req_op is valid.
REQ-009 On accept, the block SHALL register op, addr, wdata and the device flag.
REQ-010 Misaligned accesses SHALL raise an exception: LH/LHU with addr[0]!=0 gives AdEL, LW with addr[1:0]!=0 gives AdEL, SH gives AdES under the same halfword rule, SW gives AdES under the same word rule.
REQ-011 A misaligned op SHALL go IDLE->RESP with no bus activity, resp_badvaddr=addr, and resp_rdata=0.
REQ-012 An aligned op SHALL go IDLE->ADDR; in ADDR, data_req=1 with data_addr, data_wr, data_wstrb and data_wdata held stable until data_addr_ok.
REQ-013 ADDR SHALL go to DATA on data_addr_ok; DATA SHALL go to RESP on data_data_ok, capturing data_rdata.
REQ-014 data_data_ok in the same cycle as data_addr_ok SHALL NOT complete the access; the data phase is sampled only in DATA.
REQ-015 Minimum latency SHALL be: accept in cycle N, data_req in N+1, addr_ok in N+1, data_ok in N+2, resp_valid in N+3.
REQ-016 RESP SHALL assert resp_valid for exactly one cycle, then go to IDLE.
REQ-017 Byte strobes (lane 3 = addr 00) SHALL be:
- SB: one-hot, wstrb[3-addr[1:0]].
- SH: 4'b1100 when addr[1]=0, otherwise 4'b0011.
- SW: 4'b1111.
- Loads: data_wstrb=0.
REQ-018 Write data SHALL be formed as follows:
- For a byte, b=wdata[7:0] is replicated to {b,b,b,b}.
- For a halfword, h={wdata[7:0],wdata[15:8]} is duplicated as {h,h}.
- For a word, the bytes are reversed when BYTE_SWAP=1 and the access is non-device, and passed through otherwise.
REQ-019 For loads, the lane SHALL be selected using the same lane mapping, and the selected byte/halfword lanes SHALL be byte-reversed into register order.
REQ-020 The load result SHALL be formed as follows:
- A word follows the same swap rule as stores.
- LB and LH sign-extend.
- LBU and LHU zero-extend.
- A store gives resp_rdata=0.
REQ-021 Timeout: a counter SHALL clear on entering DATA and increment each DATA cycle.
REQ-022 When the counter reaches TIMEOUT_CYC without data_ok, the block SHALL go to RESP with resp_exc=3, resp_badvaddr=addr, and resp_rdata=0.
REQ-023 A data_data_ok arriving after a timeout SHALL be ignored.
REQ-024 When flush=1, it SHALL take priority over every other event, and the killed op SHALL produce no resp_valid.
REQ-025 Flush in ADDR without data_addr_ok SHALL send the block to IDLE, with data_req dropped the next cycle.
REQ-026 Flush in ADDR with data_addr_ok, or in DATA without data_ok, SHALL send the block to DRAIN; DRAIN waits for data_data_ok (or timeout), discards it, then goes to IDLE.
REQ-027 Flush in DATA with data_ok in the same cycle SHALL send the block to IDLE, discarding the data.
REQ-028 Flush in RESP SHALL suppress resp_valid, and the block SHALL go to IDLE.
REQ-029 busy SHALL be 1 in every state except IDLE.

Reset
REQ-030 On cpu_rst=1 at a clock edge, the block SHALL go to IDLE, with all outputs 0 and the timeout counter 0, from any state including mid-transaction.
REQ-031 After reset, the block SHALL accept a request in the first cycle with cpu_rst=0.

Verification
REQ-032 LB at addr 0x1003 with data_rdata=0x000000F0 and addr_ok/data_ok immediate -> wstrb=0, resp_rdata=0xFFFFFFF0, resp_valid three cycles after accept.
REQ-033 SH at 0x2002 with wdata=0x0000ABCD -> data_wstrb=4'b0011, data_wdata=0xCDABCDAB, data_wr=1; data_req held through 3 cycles of addr_ok=0.
REQ-034 LW at 0x3001 -> no data_req, resp_exc=1, resp_badvaddr=0x3001; SW at 0x3002 -> resp_exc=2.
REQ-035 LW at 0xBFAFF008 with rdata=0x11223344 -> resp_rdata=0x11223344; LW at 0x00000008 with BYTE_SWAP=1 -> 0x44332211.
REQ-036 Flush one cycle after addr_ok, data_ok 4 cycles later -> no resp_valid, busy=1 until data_ok, next request accepted the cycle after.
REQ-037 With TIMEOUT_CYC=4 and data_ok never asserted -> resp_exc=3 after 4 DATA cycles; cpu_rst asserted mid-DATA in a separate run -> IDLE with data_req=0 the next cycle.
